// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared pipeline definitions.
//   - Reset polarity, NOP/zero constants, write-enable and delay-slot encodings.
//   - Default bus widths for the ALU opcode, ALU select, register data and
//     register address fields.
//   - Stage-register control encoding, plus a helper that derives the ID/EX
//     control from the flush/stall inputs.
// Related optional feature macro: ID_EX_PERF_EN (used in id_ex_pipe).
package id_ex_pipe_pkg;

  localparam logic        RstEnable      = 1'b1;
  localparam logic        RstDisable     = 1'b0;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        WriteEnable    = 1'b1;
  localparam logic        WriteDisable   = 1'b0;
  localparam logic        IsDelaySlot    = 1'b1;
  localparam logic        IsNotDelaySlot = 1'b0;

  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [AluOpBus-1:0]   EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [AluSelBus-1:0]  EXE_RES_NOP = 3'b000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr  = 5'b00000;

  // Control applied to a pipeline stage register on the next edge.
  typedef enum logic [1:0] {
    CTL_LOAD   = 2'b00,
    CTL_BUBBLE = 2'b01,
    CTL_HOLD   = 2'b10
  } stage_ctl_e;

  // A flush always wins; a stalled ID feeding a running EX inserts a bubble;
  // a stalled EX freezes everything; otherwise the stage advances.
  function automatic stage_ctl_e ex_stage_ctl(input logic flush,
                                              input logic stall_id,
                                              input logic stall_ex);
    stage_ctl_e ctl;
    if (flush) begin
      ctl = CTL_BUBBLE;
    end else if (stall_id && !stall_ex) begin
      ctl = CTL_BUBBLE;
    end else if (stall_ex) begin
      ctl = CTL_HOLD;
    end else begin
      ctl = CTL_LOAD;
    end
    return ctl;
  endfunction

endpackage

// File: rtl/id_ex_pipe_stage_reg.sv
// id_ex_pipe_stage_reg: generic W-bit pipeline stage register.
//   Parameters: W (width), RESET_VAL (value on reset and on a bubble).
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset
//     ctl  in   CTL_LOAD / CTL_BUBBLE / CTL_HOLD
//     d    in   W-bit next value used on CTL_LOAD
//     q    out  W-bit registered value
// The same block serves the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
module id_ex_pipe_stage_reg
  import id_ex_pipe_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  stage_ctl_e     ctl,
  input  logic [W-1:0]   d,
  output logic [W-1:0]   q
);

  // Stage register: reset, then load / bubble / hold as commanded.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      q <= RESET_VAL;
    end else begin
      case (ctl)
        CTL_LOAD:   q <= d;
        CTL_BUBBLE: q <= RESET_VAL;
        CTL_HOLD:   q <= q;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: parametrised ID/EX pipeline register.
//   Moves the decoded instruction from ID to EX with one cycle of latency,
//   with flush / bubble / hold control, a valid bit, delay-slot feedback to
//   ID, and load-use hazard detection.
// Parameters: DATA_W, REG_ADDR_W, ALUOP_W, ALUSEL_W.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_id_i, stall_ex_i        stage stalls from the control unit
//   flush_i                       kill the instruction in ID
//   id_*                          decoded instruction fields from ID
//   ex_*                          registered copies presented to EX
//   now_in_delayslot_o            delay-slot feedback to ID
//   stallreq_o                    combinational load-use stall request
// Optional: define ID_EX_PERF_EN to add perf_bubble_cnt_o and
//   perf_hold_cnt_o, saturating counts of bubble and hold cycles.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_id_i,
  input  logic                  stall_ex_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [ALUOP_W-1:0]    id_aluop_i,
  input  logic [ALUSEL_W-1:0]   id_alusel_i,
  input  logic [DATA_W-1:0]     id_rdata1_i,
  input  logic [DATA_W-1:0]     id_rdata2_i,
  input  logic [REG_ADDR_W-1:0] id_waddr_reg_i,
  input  logic                  id_we_reg_i,
  input  logic                  id_is_load_i,
  input  logic                  id_re1_i,
  input  logic                  id_re2_i,
  input  logic [REG_ADDR_W-1:0] id_raddr1_i,
  input  logic [REG_ADDR_W-1:0] id_raddr2_i,
  input  logic                  id_now_in_delayslot_i,
  input  logic                  id_next_in_delayslot_i,
  input  logic [DATA_W-1:0]     id_return_addr_i,
  output logic                  ex_valid_o,
  output logic [ALUOP_W-1:0]    ex_aluop_o,
  output logic [ALUSEL_W-1:0]   ex_alusel_o,
  output logic [DATA_W-1:0]     ex_rdata1_o,
  output logic [DATA_W-1:0]     ex_rdata2_o,
  output logic [REG_ADDR_W-1:0] ex_waddr_reg_o,
  output logic                  ex_we_reg_o,
  output logic                  ex_is_load_o,
  output logic                  ex_now_in_delayslot_o,
  output logic [DATA_W-1:0]     ex_return_addr_o,
  output logic                  now_in_delayslot_o,
  output logic                  stallreq_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]           perf_bubble_cnt_o,
  output logic [31:0]           perf_hold_cnt_o
`endif
);

  localparam int FIELD_W = 4 + ALUOP_W + ALUSEL_W + 3 * DATA_W + REG_ADDR_W;

  // The NOP bubble: every field at its idle encoding, valid cleared.
  localparam logic [FIELD_W-1:0] EX_BUBBLE = {
    1'b0,
    ALUOP_W'(EXE_NOP_OP),
    ALUSEL_W'(EXE_RES_NOP),
    DATA_W'(ZeroWord),
    DATA_W'(ZeroWord),
    REG_ADDR_W'(NOPRegAddr),
    WriteDisable,
    1'b0,
    IsNotDelaySlot,
    DATA_W'(ZeroWord)
  };

  stage_ctl_e         ex_ctl;
  stage_ctl_e         ds_ctl;
  logic [FIELD_W-1:0] ex_d;
  logic [FIELD_W-1:0] ex_q;
  logic               ds_d;
  logic               ds_q;
  logic               hit1;
  logic               hit2;

  assign ex_ctl = ex_stage_ctl(flush_i, stall_id_i, stall_ex_i);

  assign ex_d = {
    id_valid_i,
    id_aluop_i,
    id_alusel_i,
    id_rdata1_i,
    id_rdata2_i,
    id_waddr_reg_i,
    id_we_reg_i,
    id_is_load_i,
    id_now_in_delayslot_i,
    id_return_addr_i
  };

  id_ex_pipe_stage_reg #(
    .W         (FIELD_W),
    .RESET_VAL (EX_BUBBLE)
  ) u_ex_reg (
    .clk (clk),
    .rst (rst),
    .ctl (ex_ctl),
    .d   (ex_d),
    .q   (ex_q)
  );

  assign {
    ex_valid_o,
    ex_aluop_o,
    ex_alusel_o,
    ex_rdata1_o,
    ex_rdata2_o,
    ex_waddr_reg_o,
    ex_we_reg_o,
    ex_is_load_o,
    ex_now_in_delayslot_o,
    ex_return_addr_o
  } = ex_q;

  // Delay-slot feedback: cleared by flush, frozen by any stall (a bubble
  // must not lose a pending delay slot), otherwise follows ID.
  always_comb begin
    if (flush_i) begin
      ds_ctl = CTL_BUBBLE;
    end else if (stall_id_i || stall_ex_i) begin
      ds_ctl = CTL_HOLD;
    end else begin
      ds_ctl = CTL_LOAD;
    end
  end

  // The instruction sitting in a delay slot cannot itself start another one.
  always_comb begin
    if (id_now_in_delayslot_i) begin
      ds_d = IsNotDelaySlot;
    end else begin
      ds_d = id_next_in_delayslot_i;
    end
  end

  id_ex_pipe_stage_reg #(
    .W         (1),
    .RESET_VAL (IsNotDelaySlot)
  ) u_ds_reg (
    .clk (clk),
    .rst (rst),
    .ctl (ds_ctl),
    .d   (ds_d),
    .q   (ds_q)
  );

  assign now_in_delayslot_o = ds_q;

  assign hit1 = id_re1_i && (id_raddr1_i == ex_waddr_reg_o);
  assign hit2 = id_re2_i && (id_raddr2_i == ex_waddr_reg_o);

  // Load-use hazard: a valid load in EX writing a non-zero register that ID
  // reads. Writes to r0 are discarded, so they never create a dependency.
  always_comb begin
    if ((rst == RstEnable) || flush_i) begin
      stallreq_o = 1'b0;
    end else begin
      stallreq_o = ex_valid_o && ex_is_load_o && (ex_we_reg_o == WriteEnable) &&
                   (ex_waddr_reg_o != REG_ADDR_W'(NOPRegAddr)) && (hit1 || hit2);
    end
  end

`ifdef ID_EX_PERF_EN
  logic bubble_cycle;
  logic hold_cycle;

  // A flush is not counted as either a stall bubble or a hold.
  assign bubble_cycle = !flush_i && stall_id_i && !stall_ex_i;
  assign hold_cycle   = !flush_i && stall_ex_i;

  // Saturating bubble / hold cycle counters.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_bubble_cnt_o <= 32'h0000_0000;
      perf_hold_cnt_o   <= 32'h0000_0000;
    end else begin
      if (bubble_cycle && (perf_bubble_cnt_o != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end else begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o;
      end
      if (hold_cycle && (perf_hold_cnt_o != 32'hFFFF_FFFF)) begin
        perf_hold_cnt_o <= perf_hold_cnt_o + 32'd1;
      end else begin
        perf_hold_cnt_o <= perf_hold_cnt_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe (default parameters).
module tb_id_ex_pipe;

  typedef struct packed {
    logic        valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  waddr;
    logic        we;
    logic        is_load;
    logic        now_ds;
    logic [31:0] ra;
    logic        nds;
  } ex_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_id, stall_ex, flush;
  logic        id_valid, id_we, id_is_load, id_re1, id_re2, id_now_ds, id_next_ds;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_r1, id_r2, id_ra;
  logic [4:0]  id_waddr, id_raddr1, id_raddr2;

  logic        ex_valid, ex_we, ex_is_load, ex_now_ds, nds, stallreq;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_r1, ex_r2, ex_ra;
  logic [4:0]  ex_waddr;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble, perf_hold;
`endif

  id_ex_pipe dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_id_i             (stall_id),
    .stall_ex_i             (stall_ex),
    .flush_i                (flush),
    .id_valid_i             (id_valid),
    .id_aluop_i             (id_aluop),
    .id_alusel_i            (id_alusel),
    .id_rdata1_i            (id_r1),
    .id_rdata2_i            (id_r2),
    .id_waddr_reg_i         (id_waddr),
    .id_we_reg_i            (id_we),
    .id_is_load_i           (id_is_load),
    .id_re1_i               (id_re1),
    .id_re2_i               (id_re2),
    .id_raddr1_i            (id_raddr1),
    .id_raddr2_i            (id_raddr2),
    .id_now_in_delayslot_i  (id_now_ds),
    .id_next_in_delayslot_i (id_next_ds),
    .id_return_addr_i       (id_ra),
    .ex_valid_o             (ex_valid),
    .ex_aluop_o             (ex_aluop),
    .ex_alusel_o            (ex_alusel),
    .ex_rdata1_o            (ex_r1),
    .ex_rdata2_o            (ex_r2),
    .ex_waddr_reg_o         (ex_waddr),
    .ex_we_reg_o            (ex_we),
    .ex_is_load_o           (ex_is_load),
    .ex_now_in_delayslot_o  (ex_now_ds),
    .ex_return_addr_o       (ex_ra),
    .now_in_delayslot_o     (nds),
    .stallreq_o             (stallreq)
`ifdef ID_EX_PERF_EN
    ,
    .perf_bubble_cnt_o      (perf_bubble),
    .perf_hold_cnt_o        (perf_hold)
`endif
  );

  ex_t obs;
  assign obs = {ex_valid, ex_aluop, ex_alusel, ex_r1, ex_r2, ex_waddr,
                ex_we, ex_is_load, ex_now_ds, ex_ra, nds};

  // Reference model state
  ex_t     exp_st;
  longint  exp_bubbles;
  longint  exp_holds;
  int      checks;
  int      errors;

  function automatic logic model_stallreq();
    if (rst || flush) return 1'b0;
    if (!(exp_st.valid && exp_st.is_load && exp_st.we && exp_st.waddr != 5'd0)) return 1'b0;
    return (id_re1 && id_raddr1 == exp_st.waddr) || (id_re2 && id_raddr2 == exp_st.waddr);
  endfunction

  // One clock edge: advance the model from the inputs seen at that edge.
  task automatic step();
    logic keep_nds;
    @(posedge clk);
    if (rst) begin
      exp_st = '0;
      exp_bubbles = 0;
      exp_holds = 0;
    end else if (flush) begin
      exp_st = '0;
    end else if (stall_id && !stall_ex) begin
      keep_nds = exp_st.nds;
      exp_st = '0;
      exp_st.nds = keep_nds;
      exp_bubbles++;
    end else if (stall_ex) begin
      exp_holds++;
    end else begin
      exp_st.valid   = id_valid;
      exp_st.aluop   = id_aluop;
      exp_st.alusel  = id_alusel;
      exp_st.r1      = id_r1;
      exp_st.r2      = id_r2;
      exp_st.waddr   = id_waddr;
      exp_st.we      = id_we;
      exp_st.is_load = id_is_load;
      exp_st.now_ds  = id_now_ds;
      exp_st.ra      = id_ra;
      exp_st.nds     = id_now_ds ? 1'b0 : id_next_ds;
    end
    #1;
  endtask

  task automatic rand_id();
    id_valid   = 1'($urandom);
    id_aluop   = 8'($urandom);
    id_alusel  = 3'($urandom);
    id_r1      = $urandom;
    id_r2      = $urandom;
    id_ra      = $urandom;
    id_waddr   = 5'($urandom);
    id_we      = 1'($urandom);
    id_is_load = 1'($urandom);
    id_re1     = 1'($urandom);
    id_re2     = 1'($urandom);
    id_raddr1  = ($urandom_range(0, 1) == 0) ? exp_st.waddr : 5'($urandom);
    id_raddr2  = ($urandom_range(0, 1) == 0) ? exp_st.waddr : 5'($urandom);
    id_now_ds  = 1'($urandom);
    id_next_ds = 1'($urandom);
  endtask

  task automatic test_reset();
    logic [116:0] zero = '0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      stall_id = 1'($urandom);
      stall_ex = 1'($urandom);
      flush    = 1'($urandom);
      step();
      checks++;
      if (obs !== zero) begin
        errors++; $display("FAIL reset_state: got %h want %h", obs, zero);
      end
      checks++;
      if (stallreq !== 1'b0) begin
        errors++; $display("FAIL reset_stallreq: got %b want 0", stallreq);
      end
    end
    rst = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; flush = 1'b0;
  endtask

  task automatic test_pass_through();
    rand_id();
    id_valid = 1'b1; id_aluop = 8'h21; id_r1 = 32'h0000_1234;
    id_waddr = 5'd7; id_we = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_aluop !== 8'h21 || ex_r1 !== 32'h0000_1234 ||
        ex_waddr !== 5'd7 || ex_we !== 1'b1) begin
      errors++; $display("FAIL pass_fixed: got %h", obs);
    end
    checks++;
    if (obs !== exp_st) begin
      errors++; $display("FAIL pass_model: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_bubble_hold();
    ex_t prev;
    rand_id(); id_valid = 1'b1;
    step();
    stall_id = 1'b1; rand_id();
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_aluop !== 8'h00 || obs !== exp_st) begin
      errors++; $display("FAIL bubble: got %h want %h", obs, exp_st);
    end
    stall_id = 1'b0; rand_id(); id_valid = 1'b1;
    step();
    prev = obs;
    stall_id = 1'b1; stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      checks++;
      if (obs !== prev || obs !== exp_st) begin
        errors++; $display("FAIL hold_%0d: got %h want %h", i, obs, exp_st);
      end
    end
    stall_id = 1'b0; stall_ex = 1'b0;
  endtask

  task automatic test_delay_slot();
    logic [3:0] want;
    rand_id(); id_now_ds = 1'b0; id_next_ds = 1'b1;
    step();
    checks++;
    if (nds !== 1'b1) begin errors++; $display("FAIL ds_branch: got %b want 1", nds); end
    id_now_ds = 1'b1; id_next_ds = 1'b0;
    step();
    checks++;
    if (nds !== 1'b0) begin errors++; $display("FAIL ds_slot: got %b want 0", nds); end
    id_now_ds = 1'b0; id_next_ds = 1'b1;
    step();
    id_now_ds = 1'b1; id_next_ds = 1'b0; stall_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (nds !== 1'b1 || obs !== exp_st) begin
        errors++; $display("FAIL ds_stall_%0d: got %b want 1", i, nds);
      end
    end
    stall_id = 1'b0;
    step();
    checks++;
    if (nds !== 1'b0) begin errors++; $display("FAIL ds_after_stall: got %b want 0", nds); end
    id_now_ds = 1'b0; id_next_ds = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    want = 4'b0000;
    if ({nds, ex_valid} !== want[1:0]) begin
      errors++; $display("FAIL ds_flush: got nds=%b valid=%b want 0 0", nds, ex_valid);
    end
  endtask

  task automatic test_load_use();
    rand_id();
    id_valid = 1'b1; id_is_load = 1'b1; id_we = 1'b1; id_waddr = 5'd5;
    id_re1 = 1'b0; id_re2 = 1'b0;
    step();
    id_re1 = 1'b1; id_raddr1 = 5'd5; #1;
    checks++;
    if (stallreq !== 1'b1) begin errors++; $display("FAIL lu_rs1: got %b want 1", stallreq); end
    id_re1 = 1'b0; id_re2 = 1'b1; id_raddr2 = 5'd5; #1;
    checks++;
    if (stallreq !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b want 1", stallreq); end
    flush = 1'b1; #1;
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_flush: got %b want 0", stallreq); end
    flush = 1'b0; id_re2 = 1'b0; #1;
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_re_off: got %b want 0", stallreq); end
    id_waddr = 5'd0;
    step();
    id_re1 = 1'b1; id_raddr1 = 5'd0; #1;
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_r0: got %b want 0", stallreq); end
    id_valid = 1'b0; id_waddr = 5'd5; id_re1 = 1'b0;
    step();
    id_re1 = 1'b1; id_raddr1 = 5'd5; #1;
    checks++;
    if (stallreq !== 1'b0 || obs !== exp_st) begin
      errors++; $display("FAIL lu_invalid: got %b want 0", stallreq);
    end
  endtask

  task automatic test_flush_priority();
`ifdef ID_EX_PERF_EN
    logic [31:0] base;
`endif
    rand_id(); id_valid = 1'b1;
    step();
    flush = 1'b1; stall_ex = 1'b1; rand_id();
    step();
    checks++;
    if (ex_valid !== 1'b0 || obs !== exp_st) begin
      errors++; $display("FAIL flush_prio: got %h want %h", obs, exp_st);
    end
    flush = 1'b0; stall_ex = 1'b0;
`ifdef ID_EX_PERF_EN
    base = perf_bubble;
`endif
    stall_id = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_id();
      step();
    end
    stall_id = 1'b0;
    checks++;
    if (obs !== exp_st) begin errors++; $display("FAIL bubble5: got %h want %h", obs, exp_st); end
`ifdef ID_EX_PERF_EN
    checks++;
    if (perf_bubble - base !== 32'd5) begin
      errors++; $display("FAIL perf_bubble5: got %0d want 5", perf_bubble - base);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      stall_id = ($urandom_range(0, 3) == 0);
      stall_ex = ($urandom_range(0, 4) == 0);
      rand_id();
      step();
      checks++;
      if (obs !== exp_st) begin
        errors++; $display("FAIL rand_state_%0d: got %h want %h", i, obs, exp_st);
      end
      checks++;
      if (stallreq !== model_stallreq()) begin
        errors++; $display("FAIL rand_stallreq_%0d: got %b want %b", i, stallreq, model_stallreq());
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (perf_bubble !== 32'(exp_bubbles) || perf_hold !== 32'(exp_holds)) begin
        errors++; $display("FAIL rand_perf_%0d: got %0d/%0d want %0d/%0d",
                           i, perf_bubble, perf_hold, exp_bubbles, exp_holds);
      end
`endif
    end
    rst = 1'b0; flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_st = '0; exp_bubbles = 0; exp_holds = 0;
    rst = 1'b1; stall_id = 1'b0; stall_ex = 1'b0; flush = 1'b0;
    rand_id();
    test_reset();
    test_pass_through();
    test_bubble_hold();
    test_delay_slot();
    test_load_use();
    test_flush_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
Parametrised ID/EX pipeline register, successor to the fixed-width decode→execute latch. Adds stall/flush control, a valid bit, full-width return address, delay-slot feedback that holds under stall, and load-use hazard detection that raises a stall request. Sits between the decode stage and the execute stage, driven by the pipeline control unit.

Parameters:
DATA_W, 32, width of operand, return-address and offset fields
REG_ADDR_W, 5, register-file address width
ALUOP_W, 8, ALU opcode width
ALUSEL_W, 3, ALU result-select width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset (RstEnable = 1'b1)
stall_id_i  in  1  decode stage stalled (ctrl stall[2])
stall_ex_i  in  1  execute stage stalled (ctrl stall[3])
flush_i  in  1  kill the instruction in ID (exception/redirect)
id_valid_i  in  1  ID holds a real instruction
id_aluop_i / id_alusel_i  in  ALUOP_W / ALUSEL_W  decoded operation
id_rdata1_i / id_rdata2_i  in  DATA_W  operands
id_waddr_reg_i  in  REG_ADDR_W  destination register
id_we_reg_i  in  1  register write enable
id_is_load_i  in  1  instruction is a load
id_re1_i / id_re2_i  in  1  source-register read enables
id_raddr1_i / id_raddr2_i  in  REG_ADDR_W  source-register addresses
id_now_in_delayslot_i  in  1  current ID instruction is in a delay slot
id_next_in_delayslot_i  in  1  next instruction will be in a delay slot
id_return_addr_i  in  DATA_W  link address
ex_valid_o  out  1  EX holds a real instruction
ex_aluop_o / ex_alusel_o / ex_rdata1_o / ex_rdata2_o / ex_waddr_reg_o / ex_we_reg_o  out  as inputs  registered copies
ex_is_load_o  out  1  registered load flag
ex_now_in_delayslot_o  out  1  registered delay-slot flag
ex_return_addr_o  out  DATA_W  registered link address
now_in_delayslot_o  out  1  delay-slot feedback to ID
stallreq_o  out  1  load-use stall request to ctrl (combinational)

Behaviour:
- Reset, synchronous: every ex_* output becomes 0; aluop = EXE_NOP_OP, alusel = EXE_RES_NOP, waddr = NOPRegAddr, we = WriteDisable, delay slot = IsNotDelaySlot, now_in_delayslot_o = 0.
- Priority at each rising edge: rst > flush_i > (stall_id_i & !stall_ex_i) > stall_ex_i > load.
- flush_i: loads a bubble into EX (all fields at their reset values, ex_valid_o = 0) and clears now_in_delayslot_o.
- Bubble (stall_id_i = 1, stall_ex_i = 0): loads the same NOP bubble into EX. now_in_delayslot_o holds its value.
- Hold (stall_ex_i = 1): every register keeps its value, including now_in_delayslot_o.
- Load (stall_id_i = 0): latches every id_* field, and ex_valid_o <= id_valid_i. now_in_delayslot_o <= id_now_in_delayslot_i ? 0 : id_next_in_delayslot_i.
- Latency: 1 cycle, ID to EX.
- stallreq_o = ex_valid_o & ex_is_load_o & ex_we_reg_o & (ex_waddr_reg_o != 0) & ((id_re1_i & id_raddr1_i == ex_waddr_reg_o) | (id_re2_i & id_raddr2_i == ex_waddr_reg_o)). Forced to 0 while rst = 1 or flush_i = 1.
- Invalid ID data: id_valid_i = 0 with we = 1 still latches, but ex_valid_o = 0 and stallreq_o stays suppressed.

Optional Feature:
ID_EX_PERF_EN:
- When defined, adds outputs perf_bubble_cnt_o[31:0] and perf_hold_cnt_o[31:0].
- perf_bubble_cnt_o increments on each bubble cycle; perf_hold_cnt_o increments on each hold cycle.
- Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, neither port nor counter exists.

Decomposition:
- Shared defines package: RstEnable, ZeroWord, EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteEnable/WriteDisable, IsDelaySlot/IsNotDelaySlot, AluOpBus/AluSelBus/RegBus/RegAddrBus widths.
- Sub-module stage_reg (parameter W, RESET_VAL): a W-bit register with load/bubble/hold controls. It is reused for IF/ID, EX/MEM and MEM/WB.

Test Plan:
- Reset: rst = 1 for 2 cycles with random id_* inputs -> all ex_* outputs 0/NOP, ex_valid_o = 0, stallreq_o = 0.
- Pass-through: aluop = 8'h21, rdata1 = 32'h0000_1234, waddr = 5'd7, we = 1, no stall -> next edge shows identical ex_* values and ex_valid_o = 1.
- Bubble vs hold:
  - stall_id_i = 1, stall_ex_i = 0 -> EX shows NOP with ex_valid_o = 0.
  - stall_id_i = 1, stall_ex_i = 1 -> EX keeps its prior instruction for 3 cycles.
- Delay slot:
  - Branch in ID (next = 1) with no stall -> now_in_delayslot_o = 1; the following delay-slot instruction (now = 1) -> 0.
  - Repeat with a 2-cycle stall between them -> value held at 1 throughout.
  - Flush -> 0.
- Load-use: EX holds lw to r5 and ID reads r5 -> stallreq_o = 1. Same with destination r0 -> 0; same with id_re1_i = 0 -> 0.
- Flush priority: flush_i = 1 together with stall_ex_i = 1 -> EX becomes a bubble. With ID_EX_PERF_EN, 5 bubble cycles -> perf_bubble_cnt_o = 5.
